// File: rtl/bcd_seg_driver.sv
// =============================================================================
// bcd_seg_driver : BCD digit to 7-segment driver with terminal-count tracking.
// Optional blink of the terminal 9 when BCD_SEG_BLINK_EN is defined.
// Rev 1.0
// =============================================================================
`default_nettype none

module bcd_seg_driver #(
    parameter int BLINK_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q,
    output logic [6:0] seg,
    output logic       done,
    output logic [7:0] run_count,
    output logic       err,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_TERM  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [6:0] C_SEG_ZERO = 7'b0111111;
    localparam logic [6:0] C_SEG_NINE = 7'b1101111;
    localparam logic [6:0] C_SEG_DASH = 7'b1000000;

    if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_blink_div
        $error("bcd_seg_driver: BLINK_DIV out of range 1..255");
    end

    logic [3:0] r_q;
    logic [3:0] r_qq;
    state_t     r_state;
    state_t     w_next;
    logic       w_done;
    logic [6:0] w_term_seg;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'b0111111;
            4'd1:    f_decode = 7'b0000110;
            4'd2:    f_decode = 7'b1011011;
            4'd3:    f_decode = 7'b1001111;
            4'd4:    f_decode = 7'b1100110;
            4'd5:    f_decode = 7'b1101101;
            4'd6:    f_decode = 7'b1111101;
            4'd7:    f_decode = 7'b0000111;
            4'd8:    f_decode = 7'b1111111;
            4'd9:    f_decode = 7'b1101111;
            default: f_decode = C_SEG_DASH;
        endcase
    endfunction

    always_comb begin
        w_next = S_FAULT;
        if (r_state != S_FAULT) begin
            if (r_q == 4'd0)      w_next = S_IDLE;
            else if (r_q <= 4'd8) w_next = S_COUNT;
            else if (r_q == 4'd9) w_next = S_TERM;
            else                  w_next = S_FAULT;
        end
    end

    // Rising edge of 9 on the pipeline, suppressed once faulted.
    assign w_done = (r_q == 4'd9) && (r_qq != 4'd9) && (r_state != S_FAULT);

`ifdef BCD_SEG_BLINK_EN
    localparam logic [7:0] C_BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [7:0] r_blink_cnt;
    logic       r_blink_on;
    logic [7:0] w_blink_cnt_nxt;
    logic       w_blink_on_nxt;

    // Counter/phase restart whenever TERM is (re)entered or left.
    always_comb begin
        w_blink_cnt_nxt = 8'd0;
        w_blink_on_nxt  = 1'b1;
        if (w_next == S_TERM && r_state == S_TERM) begin
            if (r_blink_cnt == C_BLINK_LAST) begin
                w_blink_on_nxt = ~r_blink_on;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + 8'd1;
                w_blink_on_nxt  = r_blink_on;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= 8'd0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end
    end

    assign w_term_seg = w_blink_on_nxt ? C_SEG_NINE : 7'b0000000;
`else
    assign w_term_seg = C_SEG_NINE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= 4'd0;
            r_qq      <= 4'd0;
            r_state   <= S_IDLE;
            seg       <= C_SEG_ZERO;
            done      <= 1'b0;
            run_count <= 8'd0;
            err       <= 1'b0;
        end else begin
            r_q     <= q;
            r_qq    <= r_q;
            r_state <= w_next;
            done    <= w_done;
            if (w_done && run_count != 8'hFF) begin
                run_count <= run_count + 8'd1;
            end
            if (w_next == S_FAULT) begin
                err <= 1'b1;
            end
            case (w_next)
                S_FAULT: seg <= C_SEG_DASH;
                S_TERM:  seg <= w_term_seg;
                default: seg <= f_decode(r_q);
            endcase
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_bcd_seg_driver.sv
// =============================================================================
// tb_bcd_seg_driver : directed + random checks of bcd_seg_driver against a
// history-based reference model. Rev 1.0
// =============================================================================
`default_nettype none

module tb_bcd_seg_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] q   = 4'd0;
    logic [6:0] seg;
    logic       done;
    logic [7:0] run_count;
    logic       err;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: previous two samples of q, state, term dwell length.
    int m_s1, m_s2, m_state, m_len, m_rc, m_done_cnt;
    logic [6:0] m_seg;
    logic       m_done, m_err;
    logic [6:0] seg_tab [0:9];

    bcd_seg_driver #(.BLINK_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .seg       (seg),
        .done      (done),
        .run_count (run_count),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int classify(input int v);
        if (v == 0) return 0;
        if (v <= 8) return 1;
        if (v == 9) return 2;
        return 3;
    endfunction

    task automatic model_edge(input int qv, input logic r);
        int ns;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_state = 0; m_len = 0;
            m_seg = 7'b0111111; m_done = 1'b0; m_rc = 0; m_err = 1'b0;
            return;
        end
        ns     = (m_state == 3) ? 3 : classify(m_s1);
        m_done = (m_s1 == 9) && (m_s2 != 9) && (m_state != 3);
        if (m_done) m_done_cnt++;
        if (m_done && m_rc < 255) m_rc++;
        if (ns == 3) m_err = 1'b1;
        m_len = (ns == 2 && m_state == 2) ? m_len + 1 : 0;
        if (ns == 3)      m_seg = 7'b1000000;
        else if (ns == 2) begin
`ifdef BCD_SEG_BLINK_EN
            m_seg = (((m_len / DIV) % 2) == 0) ? 7'b1101111 : 7'b0000000;
`else
            m_seg = 7'b1101111;
`endif
        end else m_seg = seg_tab[m_s1];
        m_s2    = m_s1;
        m_s1    = qv;
        m_state = ns;
    endtask

    task automatic step(input int qv, input logic r);
        q   = qv[3:0];
        rst = r;
        @(posedge clk);
        model_edge(qv, r);
        #1;
        chk("seg",       {1'b0, seg},       {1'b0, m_seg});
        chk("state",     {6'd0, state},     8'(m_state));
        chk("done",      {7'd0, done},      {7'd0, m_done});
        chk("err",       {7'd0, err},       {7'd0, m_err});
        chk("run_count", run_count,         8'(m_rc));
    endtask

    initial begin
        int start_cnt;
        seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;
        m_done_cnt = 0;

        // Reset then count 0..9 and hold at 9.
        step(0, 1'b1);
        chk("reset_seg", {1'b0, seg}, 8'h3F);
        chk("reset_cnt", run_count, 8'd0);
        for (int i = 0; i <= 9; i++) step(i, 1'b0);
        for (int i = 0; i < 12; i++) step(9, 1'b0);
        chk("count_one_done", run_count, 8'd1);
        chk("count_end_term", {6'd0, state}, 8'd2);

        // Held 9, drop to 0 for one cycle, return to 9.
        for (int i = 0; i < 20; i++) step(9, 1'b0);
        step(0, 1'b0);
        for (int i = 0; i < 6; i++) step(9, 1'b0);
        chk("redo_two_done", run_count, 8'd2);

        // Invalid code during COUNT, then recovery only via reset.
        step(0, 1'b1);
        step(3, 1'b0); step(4, 1'b0); step(12, 1'b0); step(5, 1'b0);
        chk("fault_seg", {1'b0, seg}, 8'h40);
        chk("fault_err", {7'd0, err}, 8'd1);
        for (int i = 0; i < 4; i++) step(5, 1'b0);
        chk("fault_sticky", {6'd0, state}, 8'd3);
        step(5, 1'b1);
        chk("fault_rst_err", {7'd0, err}, 8'd0);
        chk("fault_rst_seg", {1'b0, seg}, 8'h3F);

        // Invalid while in TERM: no done.
        for (int i = 0; i < 4; i++) step(9, 1'b0);
        start_cnt = m_done_cnt;
        step(14, 1'b0); step(9, 1'b0); step(9, 1'b0); step(0, 1'b0); step(9, 1'b0);
        step(9, 1'b0);
        chk("term_fault_no_done", 8'(m_done_cnt - start_cnt), 8'd0);
        chk("term_fault_state", {6'd0, state}, 8'd3);

        // Saturation of run_count.
        step(0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(9, 1'b0);
            step(0, 1'b0);
        end
        step(0, 1'b0);
        chk("sat_255", run_count, 8'd255);

        // Long 9 hold (blink or steady), reset mid-way.
        step(0, 1'b1);
        for (int i = 0; i < 19; i++) step(9, 1'b0);
        step(9, 1'b1);
        chk("blink_rst_seg", {1'b0, seg}, 8'h3F);

        // Random stimulus, mostly legal codes.
        for (int i = 0; i < 600; i++) begin
            int v;
            int pick;
            pick = $urandom_range(0, 99);
            if (pick < 35)      v = 9;
            else if (pick < 97) v = $urandom_range(0, 9);
            else                v = $urandom_range(10, 15);
            step(v, ($urandom_range(0, 39) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
